sha256_stream_padder: RTL and testbench

//  Front end for the SHA-256 compression core. Accepts a byte message as a valid/ready stream,

---
 rtl/sha256_pkg.sv | 10 +
 rtl/sha256_pad_mask.sv | 13 +
 rtl/sha256_stream_padder.sv | 116 +++++++++++
 tb/tb_sha256_stream_padder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 front end: block geometry and padder FSM encoding.
package sha256_pkg;
    localparam int SHA256_BLOCK_BYTES = 64;
    localparam int SHA256_LEN_OFFSET  = 56;

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_PAD   = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_LEN   = 2'd3;
endpackage

// File: rtl/sha256_pad_mask.sv
// Byte keep mask (bytes below idx) and 0x80 marker at byte idx; idx==64 keeps all, no marker.
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  logic [6:0]   idx,
    output logic [511:0] keep,
    output logic [511:0] marker
);
    for (genvar b = 0; b < SHA256_BLOCK_BYTES; b++) begin : g_byte
        assign keep[511-8*b -: 8]   = (7'(b) < idx)  ? 8'hFF : 8'h00;
        assign marker[511-8*b -: 8] = (7'(b) == idx) ? 8'h80 : 8'h00;
    end
endmodule

// File: rtl/sha256_stream_padder.sv
// Byte stream to FIPS 180-4 padded 512-bit blocks with first/last tags for the SHA-256 core.
module sha256_stream_padder
    import sha256_pkg::*;
#(
    parameter int BYTES_PER_BEAT = 4,
    localparam int NB_W = $clog2(BYTES_PER_BEAT) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [8*BYTES_PER_BEAT-1:0] s_data,
    input  logic                        s_last,
    input  logic [NB_W-1:0]             s_nbytes,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [511:0]                m_block,
    output logic                        m_first,
    output logic                        m_last,
    output logic [63:0]                 msg_bits
);
    localparam logic [6:0] BPB = 7'(BYTES_PER_BEAT);

    logic [1:0]   state;
    logic [511:0] blk_buf, acc_buf, keep, marker;
    logic [63:0]  wr_en;
    logic [6:0]   idx, idx_next, n_bytes, nb_ext;
    logic [60:0]  byte_cnt;
    logic [63:0]  bitlen;
    logic         first_f, final_f, need_len, mark_pending, accept, len_fits;

    // Held low while rst is asserted even though the state register already sits in S_ACCUM.
    assign s_ready  = (state == S_ACCUM) && !rst;
    assign accept   = s_valid && s_ready;
    assign nb_ext   = 7'(s_nbytes);
    assign n_bytes  = !s_last ? BPB : ((nb_ext > BPB) ? BPB : nb_ext);
    assign idx_next = idx + n_bytes;
    assign bitlen   = {byte_cnt, 3'b000};
    assign len_fits = idx <= 7'(SHA256_LEN_OFFSET - 1);

    // idx is always a multiple of the beat width, so byte b always comes from lane b % BPB.
    for (genvar b = 0; b < SHA256_BLOCK_BYTES; b++) begin : g_lane
        localparam int LANE = b % BYTES_PER_BEAT;
        assign wr_en[b] = (7'(b) >= idx) && (7'(b) < idx_next);
        assign acc_buf[511-8*b -: 8] = wr_en[b] ? s_data[8*(BYTES_PER_BEAT-1-LANE) +: 8]
                                                : blk_buf[511-8*b -: 8];
    end

    sha256_pad_mask u_mask (
        .idx    (idx),
        .keep   (keep),
        .marker (marker)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_ACCUM;
            blk_buf      <= '0;
            idx          <= '0;
            byte_cnt     <= '0;
            first_f      <= 1'b1;
            final_f      <= 1'b0;
            need_len     <= 1'b0;
            mark_pending <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: if (accept) begin
                    blk_buf  <= acc_buf;
                    idx      <= idx_next;
                    byte_cnt <= byte_cnt + 61'(n_bytes);
                    if (s_last) begin
                        state <= S_PAD;
                    end else if (idx_next == 7'(SHA256_BLOCK_BYTES)) begin
                        state    <= S_EMIT;
                        final_f  <= 1'b0;
                        need_len <= 1'b0;
                    end
                end
                S_PAD: begin
                    blk_buf      <= (blk_buf & keep) | marker | (len_fits ? {448'b0, bitlen} : 512'b0);
                    mark_pending <= (idx == 7'(SHA256_BLOCK_BYTES));
                    final_f      <= len_fits;
                    need_len     <= !len_fits;
                    state        <= S_EMIT;
                end
                S_EMIT: if (m_ready) begin
                    first_f <= 1'b0;
                    if (final_f) begin
                        idx      <= '0;
                        byte_cnt <= '0;
                        first_f  <= 1'b1;
                        state    <= S_ACCUM;
                    end else if (need_len) begin
                        state <= S_LEN;
                    end else begin
                        idx   <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_LEN: begin
                    blk_buf  <= {mark_pending ? 8'h80 : 8'h00, 440'b0, bitlen};
                    final_f  <= 1'b1;
                    need_len <= 1'b0;
                    state    <= S_EMIT;
                end
                default: state <= S_ACCUM;
            endcase
        end
    end

    assign m_valid  = (state == S_EMIT);
    assign m_block  = blk_buf;
    assign m_first  = m_valid && first_f;
    assign m_last   = m_valid && final_f;
    assign msg_bits = bitlen;
endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: three widths (1/4/8 bytes per beat) against a queue-based padding model.
module tb_sha256_stream_padder;
    logic         clk, rst;
    logic         sv [3], sr [3], sl [3], mv [3], mr [3], mf [3], ml [3];
    logic [63:0]  sd [3], mbits [3];
    logic [3:0]   snb [3];
    logic [511:0] mb [3];

    typedef struct {
        logic [511:0] blk;
        logic         f, l;
        logic [63:0]  bits;
        int           cyc;
    } obs_t;

    typedef struct {
        int k; int len; bit zt; int nbx; int rnd; int exp_nblk;
    } vec_t;

    obs_t         got [$];
    logic [511:0] exp_q [$];
    logic [7:0]   msg_q [$];
    int checks = 0, errors = 0, cyc = 0, k_act = 0, mode = 0;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int B  = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        localparam int NW = $clog2(B) + 1;
        sha256_stream_padder #(.BYTES_PER_BEAT(B)) u_dut (
            .clk(clk), .rst(rst), .s_valid(sv[g]), .s_ready(sr[g]), .s_data(sd[g][8*B-1:0]),
            .s_last(sl[g]), .s_nbytes(snb[g][NW-1:0]), .m_valid(mv[g]), .m_ready(mr[g]),
            .m_block(mb[g]), .m_first(mf[g]), .m_last(ml[g]), .msg_bits(mbits[g]));
    end

    always #5 clk = ~clk;

    function automatic int bpb(int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(logic [255:0] h, logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + w[i-7] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [255:0] digest_got();
        logic [255:0] h = IV;
        foreach (got[j]) h = compress(h, got[j].blk);
        return h;
    endfunction

    // Reference padding: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
    task automatic build_exp();
        logic [7:0]   p [$];
        logic [63:0]  bl;
        logic [511:0] b;
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        exp_q.delete();
        for (int j = 0; j < p.size() / 64; j++) begin
            b = '0;
            for (int i = 0; i < 64; i++) b = {b[503:0], p[64*j+i]};
            exp_q.push_back(b);
        end
    endtask

    task automatic fill_rand(int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drive_beat(int k, int start, int cnt, bit last, int nb);
        int B = bpb(k);
        int t = 0;
        logic [63:0] d = '0;
        for (int l = 0; l < B; l++)
            d |= 64'((l < cnt) ? msg_q[start+l] : 8'($urandom_range(0, 255))) << (8 * (B - 1 - l));
        sv[k] = 1'b1; sd[k] = d; sl[k] = last; snb[k] = 4'(nb);
        while (!sr[k] && t < 3000) begin @(negedge clk); t++; end
        if (!sr[k]) chk("beat_accept_timeout", 0, 1);
        else @(negedge clk);
        sv[k] = 1'b0; sl[k] = 1'b0;
    endtask

    task automatic send_bytes(int k, bit zt, int nbx);
        int B = bpb(k);
        int L = msg_q.size();
        int i = 0;
        int rem;
        while ((L - i) > B || ((L - i) == B && zt)) begin
            drive_beat(k, i, B, 1'b0, B);
            i += B;
        end
        rem = L - i;
        drive_beat(k, i, rem, 1'b1, (rem == B) ? rem + nbx : rem);
    endtask

    task automatic wait_blocks(int n);
        int t = 0;
        while (got.size() < n && t < 3000) begin @(negedge clk); t++; end
        if (got.size() < n) chk("block_timeout", got.size(), n);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_msg(int k, bit zt, int nbx);
        int n;
        build_exp();
        got.delete();
        k_act = k;
        send_bytes(k, zt, nbx);
        wait_blocks(exp_q.size());
        n = exp_q.size();
        chk("nblocks", got.size(), n);
        for (int j = 0; j < n && j < got.size(); j++) begin
            chk("block", got[j].blk, exp_q[j]);
            chk("m_first", got[j].f, j == 0);
            chk("m_last", got[j].l, j == n - 1);
        end
        if (got.size() == n) chk("msg_bits", got[n-1].bits, 64'(msg_q.size()) * 64'd8);
    endtask

    // Block collector plus hold-stable check while m_ready is low.
    initial begin
        bit           stall_p = 1'b0;
        logic [511:0] blk_p = '0;
        obs_t         o;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && stall_p) begin
                chk("stall_valid", mv[k_act], 1);
                chk("stall_block", mb[k_act], blk_p);
            end
            stall_p = mv[k_act] && !mr[k_act] && !rst;
            blk_p   = mb[k_act];
            if (!rst && mv[k_act] && mr[k_act]) begin
                o.blk = mb[k_act]; o.f = mf[k_act]; o.l = ml[k_act]; o.bits = mbits[k_act]; o.cyc = cyc;
                got.push_back(o);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            mr[k] = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [11];
        logic [511:0] cap_b;
        logic         cap_f, cap_l;
        int           t;
        clk = 1'b0; rst = 1'b1;
        for (int k = 0; k < 3; k++) begin sv[k] = 0; sd[k] = '0; sl[k] = 0; snb[k] = '0; mr[k] = 1; end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_s_ready", sr[k], 0);   chk("rst_m_valid", mv[k], 0);
            chk("rst_m_block", mb[k], 0);   chk("rst_m_first", mf[k], 0);
            chk("rst_m_last", ml[k], 0);    chk("rst_msg_bits", mbits[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("post_rst_s_ready", sr[k], 1);

        // "abc", one byte per beat
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 0, 0);
        chk("abc_block", got[0].blk, {32'h61626380, 416'h0, 64'h18});
        chk("abc_digest", digest_got(), 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        chk("msg_bits_cleared", mbits[0], 0);

        // empty message: zero-byte last beat at idx 0
        msg_q.delete();
        run_msg(1, 0, 0);
        chk("empty_block", got[0].blk, {8'h80, 504'h0});
        chk("empty_digest", digest_got(), 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        // 56 bytes: length spills into a second block
        fill_rand(56);
        run_msg(2, 0, 0);
        chk("b56_blk1_last", got[0].l, 0);
        chk("b56_blk2", got[1].blk, {448'h0, 64'h1c0});
        chk("b56_blk2_first", got[1].f, 0);

        // 64 bytes: marker and length both in block 2, one idle cycle between
        fill_rand(64);
        run_msg(2, 0, 0);
        chk("b64_blk2", got[1].blk, {8'h80, 440'h0, 64'h200});
        chk("b64_gap", got[1].cyc - got[0].cyc, 2);

        // downstream stall for 7 cycles
        fill_rand(10);
        build_exp();
        got.delete();
        k_act = 1;
        mode = 2;
        send_bytes(1, 0, 0);
        t = 0;
        while (!mv[1] && t < 100) begin @(negedge clk); t++; end
        chk("stall_reach_emit", mv[1], 1);
        cap_b = mb[1]; cap_f = mf[1]; cap_l = ml[1];
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("hold_valid", mv[1], 1);   chk("hold_block", mb[1], cap_b);
            chk("hold_first", mf[1], cap_f); chk("hold_last", ml[1], cap_l);
            chk("hold_s_ready", sr[1], 0);
        end
        mode = 0;
        wait_blocks(1);
        chk("stall_block_value", got[0].blk, exp_q[0]);
        fill_rand(5);
        run_msg(1, 0, 0);
        fill_rand(70);
        run_msg(1, 0, 0);

        // table of boundary lengths, zero-byte terminators and clamped s_nbytes
        tbl = '{'{0, 3, 0, 0, 0, 1}, '{1, 0, 0, 0, 1, 1}, '{2, 56, 0, 0, 1, 2}, '{1, 55, 0, 0, 0, 1},
                '{1, 60, 1, 0, 1, 2}, '{2, 119, 0, 0, 0, 2}, '{2, 120, 0, 0, 1, 3}, '{1, 64, 0, 3, 0, 2},
                '{0, 65, 0, 0, 1, 2}, '{2, 48, 1, 0, 0, 1}, '{2, 16, 0, 7, 1, 1}};
        foreach (tbl[i]) begin
            mode = tbl[i].rnd;
            fill_rand(tbl[i].len);
            run_msg(tbl[i].k, tbl[i].zt, tbl[i].nbx);
            chk("tbl_nblocks", got.size(), tbl[i].exp_nblk);
        end

        // randomized messages against the model
        for (int i = 0; i < 25; i++) begin
            int k = $urandom_range(0, 2);
            int B = bpb(k);
            mode = $urandom_range(0, 1);
            fill_rand($urandom_range(0, 140));
            run_msg(k, 1'($urandom_range(0, 1)), (B > 1) ? $urandom_range(0, B - 1) : 0);
        end

        // reset mid-block at idx 20, then "abc" again
        mode = 0;
        k_act = 0;
        fill_rand(20);
        got.delete();
        for (int i = 0; i < 20; i++) drive_beat(0, i, 1, 1'b0, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_m_valid", mv[0], 0);
        chk("midrst_s_ready", sr[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_block", got.size(), 0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 0, 0);
        chk("rst_abc_block", got[0].blk, {32'h61626380, 416'h0, 64'h18});
        chk("rst_abc_digest", digest_got(), 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
